// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer and frame store for the 8x8 red/green LED matrix Pmod.
// Define MATRIX_SCAN_DBUF_EN for a double-buffered store with tear-free swap; otherwise a single bank.
module matrix_scan_ctrl #(
    parameter int CLK_DIV = 2700
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       wr_color,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic       clr_n,
    output logic       mat_CLOCK,
    output logic       mat_RCLOCK,
    output logic       ROW,
    output logic       COL_Red,
    output logic       COL_Green
);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_SETUP    = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] div_cnt_r;
    logic [2:0]       row_r;
    logic [2:0]       bit_r;
    logic             pend_r;
    logic             tick_s;
    logic [2:0]       row_nx_s;
    logic [2:0]       bit_nx_s;
    logic             enter_setup_s;
    logic             boundary_s;
    logic             swap_s;
    logic [7:0]       red_row_s;
    logic [7:0]       green_row_s;

    assign tick_s     = (div_cnt_r == CNT_W'(CLK_DIV - 1));
    assign boundary_s = tick_s && (state_r == ST_LATCH) && (row_r == 3'd7);
    assign swap_s     = boundary_s && (pend_r || swap_req);

    // scan tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // row/bit the scan moves to when it next enters SETUP
    always_comb begin
        row_nx_s      = row_r;
        bit_nx_s      = bit_r;
        enter_setup_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                row_nx_s      = 3'd0;
                bit_nx_s      = 3'd0;
                enter_setup_s = tick_s;
            end
            ST_SHIFT_HI: begin
                bit_nx_s      = bit_r + 3'd1;
                enter_setup_s = tick_s && (bit_r != 3'd7);
            end
            ST_LATCH: begin
                row_nx_s      = row_r + 3'd1;
                bit_nx_s      = 3'd0;
                enter_setup_s = tick_s;
            end
            default: begin
                row_nx_s      = row_r;
                bit_nx_s      = bit_r;
                enter_setup_s = 1'b0;
            end
        endcase
    end

`ifdef MATRIX_SCAN_DBUF_EN
    logic [7:0] store_r [2][2][8];
    logic       sel_r;
    logic       sel_nx_s;
    logic       wr_hit_s;

    assign sel_nx_s = swap_s ? ~sel_r : sel_r;
    // A write lands in the old back bank, which is the new front only when swapping this cycle.
    assign wr_hit_s    = wr_en && swap_s && (wr_row == row_nx_s);
    assign red_row_s   = (wr_hit_s && !wr_color) ? wr_data : store_r[sel_nx_s][1'b0][row_nx_s];
    assign green_row_s = (wr_hit_s &&  wr_color) ? wr_data : store_r[sel_nx_s][1'b1][row_nx_s];

    // back-bank writes and front/back select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int r = 0; r < 8; r++) begin
                        store_r[b][c][r] <= 8'h00;
                    end
                end
            end
        end else begin
            if (wr_en) begin
                store_r[~sel_r][wr_color][wr_row] <= wr_data;
            end
            if (swap_s) begin
                sel_r <= ~sel_r;
            end
        end
    end
`else
    logic [7:0] store_r [2][8];
    logic       wr_hit_s;

    assign wr_hit_s    = wr_en && (wr_row == row_nx_s);
    assign red_row_s   = (wr_hit_s && !wr_color) ? wr_data : store_r[1'b0][row_nx_s];
    assign green_row_s = (wr_hit_s &&  wr_color) ? wr_data : store_r[1'b1][row_nx_s];

    // single scanned bank, written directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 8; r++) begin
                    store_r[c][r] <= 8'h00;
                end
            end
        end else if (wr_en) begin
            store_r[wr_color][wr_row] <= wr_data;
        end
    end
`endif

    // scan FSM with registered matrix outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            row_r       <= 3'd0;
            bit_r       <= 3'd0;
            pend_r      <= 1'b0;
            clr_n       <= 1'b0;
            mat_CLOCK   <= 1'b0;
            mat_RCLOCK  <= 1'b0;
            ROW         <= 1'b0;
            COL_Red     <= 1'b0;
            COL_Green   <= 1'b0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            if (swap_req) begin
                pend_r <= 1'b1;
            end
            if (enter_setup_s) begin
                ROW       <= (bit_nx_s == row_nx_s);
                COL_Red   <= ~red_row_s[bit_nx_s];
                COL_Green <= ~green_row_s[bit_nx_s];
            end
            if (tick_s) begin
                case (state_r)
                    ST_CLEAR: begin
                        clr_n   <= 1'b1;
                        row_r   <= row_nx_s;
                        bit_r   <= bit_nx_s;
                        state_r <= ST_SETUP;
                    end
                    ST_SETUP: begin
                        mat_CLOCK <= 1'b1;
                        state_r   <= ST_SHIFT_HI;
                    end
                    ST_SHIFT_HI: begin
                        mat_CLOCK <= 1'b0;
                        if (bit_r == 3'd7) begin
                            mat_RCLOCK <= 1'b1;
                            state_r    <= ST_LATCH;
                        end else begin
                            bit_r   <= bit_nx_s;
                            state_r <= ST_SETUP;
                        end
                    end
                    ST_LATCH: begin
                        mat_RCLOCK <= 1'b0;
                        row_r      <= row_nx_s;
                        bit_r      <= bit_nx_s;
                        state_r    <= ST_SETUP;
                        if (boundary_s) begin
                            frame_start <= 1'b1;
                            if (swap_s) begin
                                swap_ack <= 1'b1;
                                pend_r   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_CLEAR;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized scoreboard bench for matrix_scan_ctrl: a frame-level model predicts the scanned rows
// and frame events; a monitor decodes the serial matrix interface and compares.
`timescale 1ns/1ps
module tb_matrix_scan_ctrl;
    localparam int D       = 2;
    localparam int QUIET   = 300;
    localparam int RST_CYC = 1538;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic       wr_color;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_start;
    logic       clr_n;
    logic       mat_CLOCK;
    logic       mat_RCLOCK;
    logic       ROW;
    logic       COL_Red;
    logic       COL_Green;

    always #5 clk = ~clk;

    matrix_scan_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_color(wr_color), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
        .clr_n(clr_n), .mat_CLOCK(mat_CLOCK), .mat_RCLOCK(mat_RCLOCK), .ROW(ROW),
        .COL_Red(COL_Red), .COL_Green(COL_Green)
    );

    typedef struct { int row; logic [7:0] red; logic [7:0] green; } row_exp_t;
    typedef struct { int cyc; logic ack; } ev_exp_t;

    row_exp_t   row_q[$];
    ev_exp_t    ev_q[$];
    logic [7:0] mem [2][2][8];
    logic       msel;
    logic       mpend;
    logic [7:0] cur_red;
    logic [7:0] cur_green;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rows_checked = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 8; r++)
                    mem[b][c][r] = 8'h00;
        msel  = 1'b0;
        mpend = 1'b0;
        cur_red   = 8'h00;
        cur_green = 8'h00;
        row_q.delete();
        ev_q.delete();
    endtask

    // pixel (r,b) is taken from the displayed frame when its SETUP begins
    task automatic enter(input int r, input int b);
        row_exp_t e;
        cur_red[b]   = mem[msel][0][r][b];
        cur_green[b] = mem[msel][1][r][b];
        if (b == 7) begin
            e.row = r; e.red = cur_red; e.green = cur_green;
            row_q.push_back(e);
        end
    endtask

    task automatic model_step(input int c);
        int k, p, q, r;
        ev_exp_t ev;
        if (wr_en) begin
`ifdef MATRIX_SCAN_DBUF_EN
            mem[~msel][wr_color][wr_row] = wr_data;
`else
            mem[msel][wr_color][wr_row] = wr_data;
`endif
        end
        if (swap_req) mpend = 1'b1;
        if ((c % D) == D - 1) begin
            k = c / D;
            if (k == 0) begin
                enter(0, 0);
            end else begin
                p = (k - 1) % 136;
                q = p % 17;
                r = p / 17;
                if (q == 16) begin
                    if (r == 7) begin
                        ev.cyc = c; ev.ack = mpend;
                        ev_q.push_back(ev);
                        if (mpend) begin
                            mpend = 1'b0;
`ifdef MATRIX_SCAN_DBUF_EN
                            msel = ~msel;
`endif
                        end
                    end
                    enter((r + 1) % 8, 0);
                end else if ((q % 2) == 1 && q < 15) begin
                    enter(r, (q + 1) / 2);
                end
            end
        end
    endtask

    // monitor: decode the shifted rows and frame events, compare with the scoreboard
    logic       prev_mclk, prev_rclk;
    int         nbits;
    logic [7:0] obs_row, obs_red, obs_green;
    always @(posedge clk) begin
        int n, q;
        logic [2:0] exp_ctrl;
        row_exp_t e;
        ev_exp_t ev;
        #1;
        if (!rst_n) begin
            prev_mclk = 1'b0; prev_rclk = 1'b0; nbits = 0;
        end else begin
            n = (cyc + 1) / D;
            if (n == 0) begin
                exp_ctrl = 3'b000;
            end else begin
                q = ((n - 1) % 136) % 17;
                exp_ctrl = {1'b1, (q % 2) == 1, q == 16};
            end
            check("clr_clk_latch", {clr_n, mat_CLOCK, mat_RCLOCK}, exp_ctrl);
            if (mat_CLOCK && !prev_mclk) begin
                if (nbits < 8) begin
                    obs_row[nbits] = ROW; obs_red[nbits] = ~COL_Red; obs_green[nbits] = ~COL_Green;
                end
                nbits++;
            end
            if (mat_RCLOCK && !prev_rclk) begin
                check("clocks_per_latch", nbits, 8);
                if (row_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL row_latch: latch at cycle %0d, no row expected", cyc);
                end else begin
                    e = row_q.pop_front();
                    check("row_select", obs_row, 8'h01 << e.row);
                    check("red_row", obs_red, e.red);
                    check("green_row", obs_green, e.green);
                    rows_checked++;
                end
                nbits = 0;
            end
            if (frame_start || swap_ack) begin
                if (ev_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL frame_event: pulse at cycle %0d, none expected", cyc);
                end else begin
                    ev = ev_q.pop_front();
                    check("frame_start_cycle", cyc, ev.cyc);
                    check("frame_start", frame_start, 1'b1);
                    check("swap_ack", swap_ack, ev.ack);
                end
            end
            prev_mclk = mat_CLOCK;
            prev_rclk = mat_RCLOCK;
        end
    end

    task automatic idle_inputs();
        wr_en = 1'b0; wr_color = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
    endtask

    task automatic run_seg(input int seg, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            idle_inputs();
            if (seg == 0 && c == RST_CYC) begin
                check("pre_reset_shift_hi", mat_CLOCK, 1'b1);
                rst_n = 1'b0;
                #1;
                check("reset_mid_frame_outs",
                      {clr_n, mat_CLOCK, mat_RCLOCK, ROW, COL_Red, COL_Green, frame_start, swap_ack}, 8'h00);
                return;
            end
            if (c >= QUIET) begin
                if ($urandom_range(7) == 0) begin
                    wr_en = 1'b1; wr_color = 1'($urandom_range(1));
                    wr_row = 3'($urandom_range(7)); wr_data = 8'($urandom_range(255));
                end
                if ($urandom_range(299) == 0) swap_req = 1'b1;
            end
            if (seg == 0 && c == 10) begin
                wr_en = 1'b1; wr_color = 1'b0; wr_row = 3'd3; wr_data = 8'h0F;
            end
            if (seg == 0 && c == 11) swap_req = 1'b1;
            if (seg == 0 && c == 136 * 3 * D + D - 1) begin
                wr_en = 1'b1; wr_color = 1'b1; wr_row = 3'd0; wr_data = 8'hFF; swap_req = 1'b1;
            end
            if (seg == 0 && c == 1430) swap_req = 1'b1;
            cyc = c;
            model_step(c);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outs",
              {clr_n, mat_CLOCK, mat_RCLOCK, ROW, COL_Red, COL_Green, frame_start, swap_ack}, 8'h00);
        rst_n = 1'b1;
        run_seg(0, RST_CYC + 1);
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        run_seg(1, 1100);
        idle_inputs();
        @(posedge clk);
        #2;
        check("events_drained", ev_q.size(), 0);
        check("rows_drained", row_q.size() <= 1, 1'b1);
        check("rows_observed", rows_checked >= 60, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
